spi_sensor_responder: RTL and testbench
=======================================

Name: spi_sensor_responder

Overview:
- SPI slave (mode 0) model of the off-chip sensor; responds to the SPI master inside main.
- Sits in the FPGA fabric or on a bench, wired MOSI_to_sensor -> mosi, miso -> MISO_from_sensor, SCLK_wire -> sclk, CS_b_wire -> cs_b, sample_CLK_out -> sample_clk.
- Holds a small 8-bit register file. Registers are read and written by 16-bit frames. The block counts sample clocks and exposes the count as a readable register.

Parameters:
- REG_COUNT, 16, number of 8-bit registers (addresses 0..REG_COUNT-1); legal range 2..127.
- ID_VALUE, 8'hA5, value returned when address 7'h7F is read.
- SYNC_STAGES, 2, synchroniser depth for sclk, cs_b, mosi and sample_clk.

Ports:
- clk, input, 1, system clock (100 MHz).
- reset, input, 1, asynchronous active-low reset. Low means reset.
- sclk, input, 1, SPI clock from master, idle low.
- cs_b, input, 1, active-low chip select.
- mosi, input, 1, serial data from master, MSB first.
- miso, output, 1, serial data to master, MSB first.
- sample_clk, input, 1, sample strobe from master.
- frame_done, output, 1, one-clk pulse when a complete 16-bit frame ends.
- frame_abort, output, 1, one-clk pulse when cs_b rises before bit 16.
- wr_en, output, 1, one-clk pulse when a register write commits.
- wr_addr, output, 7, address of the committed write.
- wr_data, output, 8, data of the committed write.

Behaviour:
- All inputs pass through SYNC_STAGES flops, then edge detection in the clk domain.
- The master must keep sclk at or below clk/8, with each SCLK phase at least 4 clk.
- Reset: every output is 0, FSM is IDLE, all registers are 0, sample counter is 0.
- Frame format, bits 15..0 MSB first:
  - bit15 = R/W, where 1 = read.
  - bits14:8 = address.
  - bits7:0 = write data; ignored on reads.
- mosi is sampled on the synchronised sclk rising edge.
- miso changes on the synchronised sclk falling edge.
- FSM:
  - IDLE: miso=0. cs_b falling -> CMD, bit counter = 0.
  - CMD: shift 8 bits into the command register. On the 8th rising edge, latch R/W and address. If read, load the shift-out register with the read value. miso stays 0 for the whole CMD phase. After the 8th bit -> DATA.
  - DATA, read: the read MSB appears on miso at the falling edge after the 8th rising edge. Each following falling edge shifts one bit. 8 bits total.
  - DATA, write: shift in 8 data bits. On the 16th rising edge -> DONE.
  - DONE: ignore further sclk edges and hold miso=0. cs_b rising -> commit, then IDLE.
  - Commit, write: if the address is writable, update the register and pulse wr_en/wr_addr/wr_data in the same clk. Pulse frame_done in both the read and write cases.
  - Any state except IDLE/DONE: cs_b rising -> frame_abort pulse, no write, return to IDLE.
- Read map:
  - addr 0: sample counter. 8-bit; increments on each synchronised sample_clk rising edge; wraps 255 -> 0. The value read is the one latched at the 8th command bit.
  - addr 1..REG_COUNT-1: register contents.
  - addr 7'h7F: ID_VALUE.
  - any other address: 8'h00.
- Write map: addr 1..REG_COUNT-1 are writable. Writes to 0, 7'h7F or out-of-range addresses are dropped: no wr_en, but frame_done still pulses.
- Simultaneous events:
  - sample_clk edge in the same clk as the read latch: the latched value is the pre-increment count.
  - cs_b rising in the same clk as the 16th sclk rising edge: the bit is taken first, then the frame commits normally.
- Reset asserted mid-frame: immediate return to the reset state. No wr_en.
- Back-to-back frames: cs_b may fall 2 clk after the commit.

Decomposition:
- Package spi_sensor_pkg holds:
  - FSM state enum: IDLE, CMD, DATA, DONE.
  - Frame widths: CMD_W=8, DATA_W=8, FRAME_W=16.
  - Address constants: ADDR_SAMPLE_CNT=7'h00, ADDR_ID=7'h7F.
- One sub-module, spi_input_sync: SYNC_STAGES synchroniser plus rise/fall pulse generation, instantiated once per input.

Test Plan:
- Reset low, then high; read addr 7'h7F (frame 16'hFF00) -> miso returns 8'hA5, frame_done=1 once, wr_en=0.
- Write 16'h0533, then read 16'h8500 -> wr_en pulse with wr_addr=7'h05, wr_data=8'h33; the read returns 8'h33.
- 300 sample_clk pulses, then read 16'h8000 -> returns 8'd44 (300 mod 256).
- cs_b raised after 11 bits of write 16'h0377 -> frame_abort=1; a later read of addr 3 returns 8'h00; no wr_en.
- Write 16'h7F12, then read addr 0x7F -> no wr_en; read returns 8'hA5. Write 16'h2099 (addr 32 with REG_COUNT=16) -> dropped; its read returns 8'h00.
- Reset pulled low during the DATA phase of write 16'h0244 -> all outputs 0; the next read of addr 2 returns 8'h00.

Source files
------------

// File: rtl/spi_sensor_pkg.sv
// Shared types and constants for the SPI sensor responder.
package spi_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CMD_W   = 8;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;

  localparam logic [6:0] ADDR_SAMPLE_CNT = 7'h00;
  localparam logic [6:0] ADDR_ID         = 7'h7F;

endpackage

// File: rtl/spi_sensor_responder_if.sv
// SPI bus plus sample strobe between the master in main and the sensor model.
interface spi_sensor_responder_if;
  logic sclk;
  logic cs_b;
  logic mosi;
  logic miso;
  logic sample_clk;

  modport master (output sclk, output cs_b, output mosi, output sample_clk, input miso);
  modport slave  (input sclk, input cs_b, input mosi, input sample_clk, output miso);
endinterface

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one asynchronous input with rise/fall pulses.
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign sync_d[gi] = d;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign prev_d = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_sensor_responder.sv
// Mode-0 SPI slave modelling the off-chip sensor: 16-bit register read/write
// frames plus a readable sample-clock counter at address 0.
module spi_sensor_responder
  import spi_sensor_pkg::*;
#(
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_sensor_responder_if.slave    spi,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic                     wr_en,
  output logic [6:0]               wr_addr,
  output logic [7:0]               wr_data
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CMD  = CMD;
  localparam logic [1:0] S_DATA = DATA;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [6:0] REG_LIMIT = 7'(REG_COUNT);
  // Input order: sclk, cs_b, mosi, sample_clk. cs_b idles high.
  localparam logic [3:0] RST_VALS  = 4'b0010;

  logic [3:0] raw_in;
  logic [3:0] lvl;
  logic [3:0] rise;
  logic [3:0] fall;

  assign raw_in = {spi.sample_clk, spi.mosi, spi.cs_b, spi.sclk};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    spi_input_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RST_VALS[gi])
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (raw_in[gi]),
      .level (lvl[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi])
    );
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_l, smp_rise;
  assign sclk_rise = rise[0];
  assign sclk_fall = fall[0];
  assign cs_rise   = rise[1];
  assign cs_fall   = fall[1];
  assign mosi_l    = lvl[2];
  assign smp_rise  = rise[3];

  logic unused_sync;
  assign unused_sync = ^{lvl[0], lvl[1], lvl[3], rise[2], fall[2], fall[3]};

  logic [1:0] state_q,       state_d;
  logic [4:0] bit_cnt_q,     bit_cnt_d;
  logic [7:0] shift_in_q,    shift_in_d;
  logic [7:0] shift_out_q,   shift_out_d;
  logic       rw_q,          rw_d;
  logic [6:0] addr_q,        addr_d;
  logic       miso_q,        miso_d;
  logic [7:0] sample_cnt_q,  sample_cnt_d;
  logic       frame_done_q,  frame_done_d;
  logic       frame_abort_q, frame_abort_d;
  logic       wr_en_q,       wr_en_d;
  logic [6:0] wr_addr_q,     wr_addr_d;
  logic [7:0] wr_data_q,     wr_data_d;
  logic [7:0] regs_q [REG_COUNT];
  logic [7:0] regs_d [REG_COUNT];

  logic [6:0] cmd_addr;
  logic [7:0] rd_val;
  logic       commit;

  assign cmd_addr = {shift_in_q[5:0], mosi_l};

  always_comb begin
    rd_val = 8'h00;
    if (cmd_addr == ADDR_SAMPLE_CNT) begin
      rd_val = sample_cnt_q;
    end else if (cmd_addr == ADDR_ID) begin
      rd_val = ID_VALUE;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (cmd_addr == 7'(i)) rd_val = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_in_d    = shift_in_q;
    shift_out_d   = shift_out_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    miso_d        = miso_q;
    sample_cnt_d  = smp_rise ? sample_cnt_q + 8'd1 : sample_cnt_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = 7'h00;
    wr_data_d     = 8'h00;
    commit        = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) regs_d[i] = regs_q[i];

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = S_CMD;
          bit_cnt_d  = 5'd0;
          shift_in_d = 8'h00;
        end
      end
      S_CMD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          state_d       = S_IDLE;
        end else if (sclk_rise) begin
          shift_in_d = {shift_in_q[6:0], mosi_l};
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(CMD_W - 1)) begin
            // Read value (including the sample count) is frozen here.
            rw_d        = shift_in_q[6];
            addr_d      = cmd_addr;
            shift_out_d = rd_val;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sclk_fall && rw_q) begin
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          shift_in_d = {shift_in_q[6:0], mosi_l};
          bit_cnt_d  = bit_cnt_q + 5'd1;
        end
        // A final bit arriving with cs_b rising still completes the frame.
        if (sclk_rise && bit_cnt_q == 5'(FRAME_W - 1)) begin
          miso_d  = 1'b0;
          state_d = S_DONE;
          commit  = cs_rise;
        end else if (cs_rise) begin
          miso_d        = 1'b0;
          frame_abort_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        miso_d = 1'b0;
        commit = cs_rise;
      end
    endcase

    if (commit) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b1;
      if (!rw_q && addr_q != ADDR_SAMPLE_CNT && addr_q < REG_LIMIT) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = shift_in_d;
        for (int i = 1; i < REG_COUNT; i++) begin
          if (addr_q == 7'(i)) regs_d[i] = shift_in_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 5'd0;
      shift_in_q    <= 8'h00;
      shift_out_q   <= 8'h00;
      rw_q          <= 1'b0;
      addr_q        <= 7'h00;
      miso_q        <= 1'b0;
      sample_cnt_q  <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 7'h00;
      wr_data_q     <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_in_q    <= shift_in_d;
      shift_out_q   <= shift_out_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      miso_q        <= miso_d;
      sample_cnt_q  <= sample_cnt_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign spi.miso    = miso_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Randomised and directed frame test of spi_sensor_responder against a
// register-map reference model.
module tb_spi_sensor_responder;

  localparam int REG_COUNT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_done;
  logic       frame_abort;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  spi_sensor_responder_if spi_bus ();

  spi_sensor_responder #(
    .REG_COUNT   (REG_COUNT),
    .ID_VALUE    (8'hA5),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi_bus),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         done_total  = 0;
  int         abort_total = 0;
  int         wr_total    = 0;
  logic [6:0] last_wr_addr = 7'h00;
  logic [7:0] last_wr_data = 8'h00;

  always @(negedge clk) begin
    if (frame_done)  done_total  <= done_total + 1;
    if (frame_abort) abort_total <= abort_total + 1;
    if (wr_en) begin
      wr_total     <= wr_total + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
  end

  // Reference model: the sensor's visible register map.
  logic [7:0] model_regs [128];
  logic [7:0] model_cnt;

  task automatic model_clear();
    for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;
    model_cnt = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'h00) return model_cnt;
    if (a == 7'h7F) return 8'hA5;
    if (int'(a) < REG_COUNT) return model_regs[a];
    return 8'h00;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts nbits of f out MSB first; rd collects miso during bits 8..15.
  task automatic xfer(input logic [15:0] f, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    spi_bus.cs_b = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      spi_bus.mosi = f[15-i];
      wait_clk(5);
      if (i >= 8) rd = {rd[6:0], spi_bus.miso};
      spi_bus.sclk = 1'b1;
      wait_clk(5);
      spi_bus.sclk = 1'b0;
    end
    wait_clk(5);
    spi_bus.cs_b = 1'b1;
    wait_clk(8);
  endtask

  task automatic run_frame(input logic [15:0] f, input string tag);
    logic [7:0] rd;
    logic [7:0] exp_rd;
    logic       wr_exp;
    int         d0, a0, w0;
    exp_rd = model_read(f[14:8]);
    wr_exp = !f[15] && f[14:8] != 7'h00 && int'(f[14:8]) < REG_COUNT;
    d0 = done_total; a0 = abort_total; w0 = wr_total;
    xfer(f, 16, rd);
    if (f[15]) check_val({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    check_val({tag, "_done"},  32'(done_total - d0),  32'd1);
    check_val({tag, "_abort"}, 32'(abort_total - a0), 32'd0);
    check_val({tag, "_wr_en"}, 32'(wr_total - w0),    32'(wr_exp));
    if (wr_exp) begin
      check_val({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(f[14:8]));
      check_val({tag, "_wr_data"}, 32'(last_wr_data), 32'(f[7:0]));
      model_regs[f[14:8]] = f[7:0];
    end
    $display("frame %s 0x%04h %s rd=0x%02h", tag, f, f[15] ? "read" : "write", rd);
  endtask

  task automatic pulse_samples(input int n);
    for (int i = 0; i < n; i++) begin
      spi_bus.sample_clk = 1'b1;
      wait_clk(3);
      spi_bus.sample_clk = 1'b0;
      wait_clk(3);
      model_cnt = model_cnt + 8'd1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_miso"},        32'(spi_bus.miso), 32'd0);
    check_val({tag, "_frame_done"},  32'(frame_done),   32'd0);
    check_val({tag, "_frame_abort"}, 32'(frame_abort),  32'd0);
    check_val({tag, "_wr_en"},       32'(wr_en),        32'd0);
    check_val({tag, "_wr_addr"},     32'(wr_addr),      32'd0);
    check_val({tag, "_wr_data"},     32'(wr_data),      32'd0);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] f;
    int          d0, a0, w0;

    reset              = 1'b0;
    spi_bus.sclk       = 1'b0;
    spi_bus.cs_b       = 1'b1;
    spi_bus.mosi       = 1'b0;
    spi_bus.sample_clk = 1'b0;
    model_clear();
    wait_clk(4);
    check_outputs_zero("reset");
    reset = 1'b1;
    wait_clk(6);
    check_outputs_zero("post_reset");

    run_frame(16'hFF00, "id_read");
    run_frame(16'h0533, "write5");
    run_frame(16'h8500, "read5");

    pulse_samples(300);
    run_frame(16'h8000, "sample_cnt");
    check_val("sample_cnt_model", 32'(model_cnt), 32'd44);

    d0 = done_total; a0 = abort_total; w0 = wr_total;
    xfer(16'h0377, 11, rd);
    check_val("abort_pulse", 32'(abort_total - a0), 32'd1);
    check_val("abort_done",  32'(done_total - d0),  32'd0);
    check_val("abort_wr_en", 32'(wr_total - w0),    32'd0);
    $display("frame abort 0x0377 after 11 bits");
    run_frame(16'h8300, "read3_after_abort");

    run_frame(16'h7F12, "write_id");
    run_frame(16'hFF00, "id_reread");
    run_frame(16'h2099, "write_oor");
    run_frame(16'hA000, "read_oor");

    for (int n = 0; n < 40; n++) begin
      f[15]   = 1'($urandom_range(0, 1));
      f[14:8] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 20));
      f[7:0]  = 8'($urandom);
      run_frame(f, "random");
      pulse_samples($urandom_range(0, 5));
    end

    // Reset in the middle of the data phase of a write to addr 2.
    w0 = wr_total;
    f = 16'h0244;
    spi_bus.cs_b = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 12; i++) begin
      spi_bus.mosi = f[15-i];
      wait_clk(5);
      spi_bus.sclk = 1'b1;
      wait_clk(5);
      spi_bus.sclk = 1'b0;
    end
    reset = 1'b0;
    wait_clk(2);
    check_outputs_zero("mid_reset");
    spi_bus.cs_b = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    model_clear();
    wait_clk(6);
    check_val("mid_reset_no_wr", 32'(wr_total - w0), 32'd0);
    $display("frame reset during write 0x0244");
    run_frame(16'h8200, "read2_after_reset");
    run_frame(16'h8000, "cnt_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
